// File: rtl/flush_request_unit.sv
// Collects redirect/halt requests, drives hazard-unit flush masks and the fetch redirect PC.
// Optional saturating retire counters are built when FLUSH_REQ_STATS_EN is defined.
module flush_request_unit #(
    parameter int PC_W    = 32,
    parameter int STATS_W = 16
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               id_jump_valid,
    input  logic [PC_W-1:0]    id_jump_pc,
    input  logic               ex_redir_valid,
    input  logic [PC_W-1:0]    ex_redir_pc,
    input  logic               halt_req,
    input  logic               pipe_advance,
    output logic [0:3]         flushes,
    output logic               redirect_valid,
    output logic [PC_W-1:0]    redirect_pc,
    output logic               halted,
    output logic [STATS_W-1:0] cnt_id_flush,
    output logic [STATS_W-1:0] cnt_ex_flush
);

    localparam logic [0:3] MASK_ID   = 4'b1000;
    localparam logic [0:3] MASK_EX   = 4'b1100;
    localparam logic [0:3] MASK_HALT = 4'b1110;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND_ID = 2'd1,
        PEND_EX = 2'd2,
        HALTED  = 2'd3
    } state_t;

    state_t          state, next_state;
    logic [PC_W-1:0] pend_pc;
    logic            load_pend;
    logic [PC_W-1:0] load_pc;
    logic [PC_W-1:0] target;
    logic            drive_id;
    logic            drive_ex;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state   <= IDLE;
            pend_pc <= '0;
        end else begin
            state <= next_state;
            if (load_pend) begin
                pend_pc <= load_pc;
            end
        end
    end

    always_comb begin
        next_state = state;
        load_pend  = 1'b0;
        load_pc    = '0;
        target     = '0;
        drive_id   = 1'b0;
        drive_ex   = 1'b0;

        // Halt outranks everything and is terminal until reset.
        if (halt_req || state == HALTED) begin
            next_state = HALTED;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ex_redir_valid) begin
                        drive_ex = 1'b1;
                        target   = ex_redir_pc;
                        if (!pipe_advance) begin
                            next_state = PEND_EX;
                            load_pend  = 1'b1;
                            load_pc    = ex_redir_pc;
                        end
                    end else if (id_jump_valid) begin
                        drive_id = 1'b1;
                        target   = id_jump_pc;
                        if (!pipe_advance) begin
                            next_state = PEND_ID;
                            load_pend  = 1'b1;
                            load_pc    = id_jump_pc;
                        end
                    end
                end
                PEND_ID: begin
                    // An EX redirect belongs to an older instruction and replaces the pending jump.
                    if (ex_redir_valid) begin
                        drive_ex   = 1'b1;
                        target     = ex_redir_pc;
                        next_state = pipe_advance ? IDLE : PEND_EX;
                        load_pend  = !pipe_advance;
                        load_pc    = ex_redir_pc;
                    end else begin
                        drive_id = 1'b1;
                        target   = pend_pc;
                        if (pipe_advance) begin
                            next_state = IDLE;
                        end
                    end
                end
                PEND_EX: begin
                    drive_ex = 1'b1;
                    target   = pend_pc;
                    if (pipe_advance) begin
                        next_state = IDLE;
                    end
                end
                default: next_state = HALTED;
            endcase
        end
    end

    always_comb begin
        flushes        = 4'b0000;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (next_state == HALTED) begin
            flushes = MASK_HALT;
        end else if (drive_ex) begin
            flushes        = MASK_EX;
            redirect_valid = 1'b1;
            redirect_pc    = {target[PC_W-1:2], 2'b00};
        end else if (drive_id) begin
            flushes        = MASK_ID;
            redirect_valid = 1'b1;
            redirect_pc    = {target[PC_W-1:2], 2'b00};
        end
    end

    assign halted = (state == HALTED);

`ifdef FLUSH_REQ_STATS_EN
    logic [STATS_W-1:0] id_cnt, ex_cnt;

    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] val);
        return (&val) ? val : val + 1'b1;
    endfunction

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            id_cnt <= '0;
            ex_cnt <= '0;
        end else if (pipe_advance && next_state != HALTED) begin
            if (drive_ex) begin
                ex_cnt <= sat_inc(ex_cnt);
            end else if (drive_id) begin
                id_cnt <= sat_inc(id_cnt);
            end
        end
    end

    assign cnt_id_flush = id_cnt;
    assign cnt_ex_flush = ex_cnt;
`else
    assign cnt_id_flush = '0;
    assign cnt_ex_flush = '0;
`endif

endmodule

// File: tb/tb_flush_request_unit.sv
// Directed bench for flush_request_unit: linear steps with hand-computed expectations.
module tb_flush_request_unit;

    localparam int PC_W    = 32;
    localparam int STATS_W = 2;
`ifdef FLUSH_REQ_STATS_EN
    localparam logic [STATS_W-1:0] EXP_ID_CNT = 2'd3;
`else
    localparam logic [STATS_W-1:0] EXP_ID_CNT = 2'd0;
`endif

    logic               CLK = 1'b0;
    logic               nRST = 1'b0;
    logic               id_jump_valid = 1'b0;
    logic [PC_W-1:0]    id_jump_pc = '0;
    logic               ex_redir_valid = 1'b0;
    logic [PC_W-1:0]    ex_redir_pc = '0;
    logic               halt_req = 1'b0;
    logic               pipe_advance = 1'b0;
    logic [0:3]         flushes;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               halted;
    logic [STATS_W-1:0] cnt_id_flush;
    logic [STATS_W-1:0] cnt_ex_flush;

    int n_cmp = 0;
    int n_err = 0;

    flush_request_unit #(.PC_W(PC_W), .STATS_W(STATS_W)) dut (
        .CLK(CLK), .nRST(nRST),
        .id_jump_valid(id_jump_valid), .id_jump_pc(id_jump_pc),
        .ex_redir_valid(ex_redir_valid), .ex_redir_pc(ex_redir_pc),
        .halt_req(halt_req), .pipe_advance(pipe_advance),
        .flushes(flushes), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted), .cnt_id_flush(cnt_id_flush), .cnt_ex_flush(cnt_ex_flush)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] f, input logic rv, input logic [PC_W-1:0] pc);
        chk({tag, ".flushes"}, 64'(flushes), 64'(f));
        chk({tag, ".rv"}, 64'(redirect_valid), 64'(rv));
        chk({tag, ".rpc"}, 64'(redirect_pc), 64'(pc));
    endtask

    task automatic clear_inputs();
        id_jump_valid  = 1'b0;
        ex_redir_valid = 1'b0;
        halt_req       = 1'b0;
        pipe_advance   = 1'b0;
    endtask

    initial begin
        // Reset
        tick(); tick();
        nRST = 1'b1;
        settle();
        chk_out("reset", 4'b0000, 1'b0, 32'h0);
        chk("reset.halted", 64'(halted), 64'd0);
        chk("reset.cnt_id", 64'(cnt_id_flush), 64'd0);
        chk("reset.cnt_ex", 64'(cnt_ex_flush), 64'd0);

        // ID jump consumed immediately
        id_jump_valid = 1'b1; id_jump_pc = 32'h0000_0044; pipe_advance = 1'b1;
        settle();
        chk_out("t1.same", 4'b1000, 1'b1, 32'h44);
        tick(); clear_inputs(); settle();
        chk_out("t1.next", 4'b0000, 1'b0, 32'h0);

        // EX redirect held across stall; low PC bits cleared
        ex_redir_valid = 1'b1; ex_redir_pc = 32'h0000_0102;
        settle();
        chk_out("t2.c1", 4'b1100, 1'b1, 32'h100);
        tick(); clear_inputs(); settle();
        chk_out("t2.c2", 4'b1100, 1'b1, 32'h100);
        tick(); settle();
        chk_out("t2.c3", 4'b1100, 1'b1, 32'h100);
        tick(); pipe_advance = 1'b1; settle();
        chk_out("t2.c4", 4'b1100, 1'b1, 32'h100);
        tick(); clear_inputs(); settle();
        chk_out("t2.c5", 4'b0000, 1'b0, 32'h0);

        // Pending ID overridden by EX; later ID in PEND_EX ignored
        id_jump_valid = 1'b1; id_jump_pc = 32'h20;
        settle();
        chk_out("t3.id", 4'b1000, 1'b1, 32'h20);
        tick(); clear_inputs(); settle();
        chk_out("t3.pend_id", 4'b1000, 1'b1, 32'h20);
        ex_redir_valid = 1'b1; ex_redir_pc = 32'h80; settle();
        chk_out("t3.override", 4'b1100, 1'b1, 32'h80);
        tick(); clear_inputs(); settle();
        chk_out("t3.pend_ex", 4'b1100, 1'b1, 32'h80);
        id_jump_valid = 1'b1; id_jump_pc = 32'h44; settle();
        chk_out("t3.ignore_id", 4'b1100, 1'b1, 32'h80);
        pipe_advance = 1'b1; settle();
        chk_out("t3.retire", 4'b1100, 1'b1, 32'h80);
        tick(); clear_inputs(); settle();
        chk_out("t3.after", 4'b0000, 1'b0, 32'h0);

        // Reset during PEND_EX discards the request
        ex_redir_valid = 1'b1; ex_redir_pc = 32'h200;
        tick(); clear_inputs(); settle();
        chk_out("t5.pend", 4'b1100, 1'b1, 32'h200);
        nRST = 1'b0;
        tick(); nRST = 1'b1; settle();
        chk_out("t5.reset", 4'b0000, 1'b0, 32'h0);
        pipe_advance = 1'b1; settle();
        chk_out("t5.adv", 4'b0000, 1'b0, 32'h0);
        tick(); settle();
        chk_out("t5.adv2", 4'b0000, 1'b0, 32'h0);
        clear_inputs();

        // Five retired ID jumps
        id_jump_valid = 1'b1; id_jump_pc = 32'h10; pipe_advance = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        clear_inputs(); settle();
        chk("t6.cnt_id", 64'(cnt_id_flush), 64'(EXP_ID_CNT));
        chk("t6.cnt_ex", 64'(cnt_ex_flush), 64'd0);

        // Simultaneous halt/EX/ID: halt wins and sticks until reset
        halt_req = 1'b1; ex_redir_valid = 1'b1; ex_redir_pc = 32'h300;
        id_jump_valid = 1'b1; id_jump_pc = 32'h400; pipe_advance = 1'b1;
        settle();
        chk_out("t4.same", 4'b1110, 1'b0, 32'h0);
        tick(); clear_inputs(); settle();
        chk_out("t4.held", 4'b1110, 1'b0, 32'h0);
        chk("t4.halted", 64'(halted), 64'd1);
        ex_redir_valid = 1'b1; pipe_advance = 1'b1;
        tick(); tick(); settle();
        chk_out("t4.ignore", 4'b1110, 1'b0, 32'h0);
        chk("t4.halted2", 64'(halted), 64'd1);
        clear_inputs();
        nRST = 1'b0;
        tick(); nRST = 1'b1; settle();
        chk_out("t4.reset", 4'b0000, 1'b0, 32'h0);
        chk("t4.halted_rst", 64'(halted), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
